// File: rtl/rv32i_types.sv
// Shared core types: architectural register constants and the commit packet.
// The retire_rat free-return bypass is enabled by defining RRAT_FREE_BYPASS_EN.
package rv32i_types;

    localparam int ARCH_REGS     = 32;
    localparam int ARCH_REG_BITS = 5;
    localparam int PHYS_REG_BITS = 6;

    typedef struct packed {
        logic                     regf_we;
        logic [ARCH_REG_BITS-1:0] rd;
        logic [PHYS_REG_BITS-1:0] pd;
        logic                     flush;
    } commit_pkt_t;

    // x0 is hardwired, so only nonzero destinations change the mapping
    function automatic logic writes_reg(input logic we,
                                        input logic [ARCH_REG_BITS-1:0] rd);
        return we && (rd != '0);
    endfunction

endpackage

// File: rtl/free_return_fifo.sv
// Small FIFO holding physical registers on their way back to the free list.
// Depth must be a power of two; count saturates at DEPTH.
module free_return_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // storage: cleared on reset so the head reads 0 while empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // pointers and occupancy; simultaneous push and pop keep count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/retire_rat.sv
// Retirement register alias table: committed mapping, free-list returns, flush pulse.
// Define RRAT_FREE_BYPASS_EN to let a return skip the empty queue in the same cycle.
module retire_rat
    import rv32i_types::*;
#(
    parameter int PHYS_REG_BITS = 6,
    parameter int FREE_Q_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    output logic                     commit_ready,
    input  logic                     commit_regf_we,
    input  logic [4:0]               commit_rd,
    input  logic [PHYS_REG_BITS-1:0] commit_pd,
    input  logic                     commit_flush,
    output logic [PHYS_REG_BITS-1:0] rrat [ARCH_REGS],
    output logic                     global_branch_signal,
    output logic                     free_valid,
    output logic [PHYS_REG_BITS-1:0] free_pd,
    input  logic                     free_ready
);

    localparam int CNT_W = $clog2(FREE_Q_DEPTH) + 1;

    logic                     accept;
    logic                     do_write;
    logic [PHYS_REG_BITS-1:0] old_pd;
    logic                     q_push;
    logic                     q_pop;
    logic [PHYS_REG_BITS-1:0] q_head;
    logic [CNT_W-1:0]         q_count;
    logic                     q_full;
    logic                     q_empty;

    assign commit_ready = !q_full;
    assign accept       = commit_valid && commit_ready;
    assign do_write     = accept && writes_reg(commit_regf_we, commit_rd);
    assign old_pd       = rrat[commit_rd];
    assign q_empty      = (q_count == '0);
    assign q_pop        = free_ready && !q_empty;

`ifdef RRAT_FREE_BYPASS_EN
    logic bypass;

    // an empty queue with a ready free list hands the old pd straight over
    assign bypass     = do_write && q_empty && free_ready;
    assign q_push     = do_write && !bypass;
    assign free_valid = !q_empty || bypass;
    assign free_pd    = bypass ? old_pd : q_head;
`else
    assign q_push     = do_write;
    assign free_valid = !q_empty;
    assign free_pd    = q_head;
`endif

    free_return_fifo #(
        .DEPTH (FREE_Q_DEPTH),
        .WIDTH (PHYS_REG_BITS)
    ) u_ret_q (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (old_pd),
        .pop       (q_pop),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full)
    );

    // committed mapping: identity after reset, x0 never rewritten
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                rrat[i] <= PHYS_REG_BITS'(i);
            end
        end else if (do_write) begin
            rrat[commit_rd] <= commit_pd;
        end
    end

    // one-cycle flush pulse for every accepted mispredicted branch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            global_branch_signal <= 1'b0;
        end else begin
            global_branch_signal <= accept && commit_flush;
        end
    end

endmodule

// File: tb/tb_retire_rat.sv
// Self-checking bench for retire_rat: scoreboard of expected free-list returns
// plus a reference copy of the committed mapping.
module tb_retire_rat;

    logic       clk;
    logic       rst;
    logic       commit_valid;
    logic       commit_ready;
    logic       commit_regf_we;
    logic [4:0] commit_rd;
    logic [5:0] commit_pd;
    logic       commit_flush;
    logic [5:0] rrat [32];
    logic       global_branch_signal;
    logic       free_valid;
    logic [5:0] free_pd;
    logic       free_ready;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_q [$];
    logic [5:0] mrat [32];

    retire_rat #(
        .PHYS_REG_BITS (6),
        .FREE_Q_DEPTH  (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .commit_valid         (commit_valid),
        .commit_ready         (commit_ready),
        .commit_regf_we       (commit_regf_we),
        .commit_rd            (commit_rd),
        .commit_pd            (commit_pd),
        .commit_flush         (commit_flush),
        .rrat                 (rrat),
        .global_branch_signal (global_branch_signal),
        .free_valid           (free_valid),
        .free_pd              (free_pd),
        .free_ready           (free_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) mrat[i] = 6'(i);
    endtask

    task automatic chk_rrat(input string tag);
        for (int i = 0; i < 32; i++) chk(tag, rrat[i], mrat[i]);
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic do_commit(input logic we, input logic [4:0] rd,
                             input logic [5:0] pd, input logic fl);
        int n = 0;
        while (!commit_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!commit_ready) begin
            chk("commit_timeout", 0, 1);
            return;
        end
        if (we && rd != 0) begin
            exp_q.push_back(mrat[rd]);
            mrat[rd] = pd;
        end
        commit_valid   = 1'b1;
        commit_regf_we = we;
        commit_rd      = rd;
        commit_pd      = pd;
        commit_flush   = fl;
        @(posedge clk); #1;
        commit_valid   = 1'b0;
        commit_flush   = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
    endtask

    // scoreboard pop on every handshake with the free list
    always @(negedge clk) begin
        if (rst && free_valid && free_ready) begin
            if (exp_q.size() == 0) chk("spurious_free", 1, 0);
            else chk("free_pd_order", free_pd, exp_q.pop_front());
        end
    end

    initial begin
        rst            = 1'b0;
        commit_valid   = 1'b0;
        commit_regf_we = 1'b0;
        commit_rd      = '0;
        commit_pd      = '0;
        commit_flush   = 1'b0;
        free_ready     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        chk("rst_rrat5", rrat[5], 5);
        chk("rst_rrat31", rrat[31], 31);
        chk("rst_free_valid", free_valid, 0);
        chk("rst_free_pd", free_pd, 0);
        chk("rst_gbs", global_branch_signal, 0);
        chk("rst_ready", commit_ready, 1);

        free_ready = 1'b1;
        do_commit(1, 5, 40, 0);
        chk("c5_rrat", rrat[5], 40);
        chk("c5_free_valid", free_valid, 1);
        chk("c5_free_pd", free_pd, 5);
        @(posedge clk); #1;
        chk("c5_free_valid_after", free_valid, 0);

        do_commit(1, 0, 41, 0);
        do_commit(0, 9, 42, 0);
        chk("x0_store_free_valid", free_valid, 0);
        chk("x0_hold", rrat[0], 0);
        chk_rrat("nowrite_rrat");

        free_ready = 1'b0;
        do_commit(1, 1, 33, 0);
        do_commit(1, 2, 34, 0);
        do_commit(1, 3, 35, 0);
        do_commit(1, 4, 36, 0);
        chk("full_ready", commit_ready, 0);
        chk("full_head", free_pd, 1);
        free_ready = 1'b1;
        #1;
        chk("full_ready_same_cycle", commit_ready, 0);
        @(posedge clk); #1;
        chk("ready_after_pop", commit_ready, 1);
        drain();
        chk_rrat("after_fill_rrat");

        do_commit(1, 7, 50, 1);
        chk("flush_gbs", global_branch_signal, 1);
        chk("flush_rrat7", rrat[7], 50);
        do_commit(1, 8, 51, 1);
        chk("flush_b2b_gbs", global_branch_signal, 1);
        @(posedge clk); #1;
        chk("flush_gbs_clear", global_branch_signal, 0);
        drain();

        free_ready = 1'b0;
        do_commit(1, 9, 52, 0);
        do_commit(1, 10, 53, 0);
        do_commit(1, 11, 54, 0);
        chk("pre_rst_free_valid", free_valid, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_free_valid", free_valid, 0);
        chk("mid_rst_ready", commit_ready, 1);
        chk_rrat("mid_rst_rrat");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_free_valid", free_valid, 0);
        chk("post_rst_gbs", global_branch_signal, 0);

        free_ready = 1'b1;
        do_commit(1, 9, 60, 0);
        chk("post_rst_free_pd", free_pd, 9);
        drain();
        chk_rrat("final_rrat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
